// File: rtl/p2s_frame_sequencer.sv
// p2s_frame_sequencer
// Walks a board frame row by row: fetches each row from a synchronous board
// memory, loads it into the downstream parallel-to-serial shifter, then gates
// DATA_SIZE shifts with SERIAL_READY. Framing strobes are registered so they
// line up with the shifter's registered serial DATA output.
module p2s_frame_sequencer #(
    parameter int DATA_SIZE = 64,
    parameter int NUM_ROWS  = 64,
    parameter int AW        = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic          ABORT,
    input  logic          SERIAL_READY,
    output logic [AW-1:0] ROW_ADDR,
    output logic          LOAD_EN,
    output logic          SHIFT_EN,
    output logic          BIT_VALID,
    output logic          ROW_LAST,
    output logic          FRAME_LAST,
    output logic          BUSY,
    output logic          DONE
);

    localparam int CW = $clog2(DATA_SIZE) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_SIZE - 1);
    localparam logic [AW-1:0] LAST_ROW = AW'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
        DRAIN
    } state_t;

    state_t        state;
    logic [AW-1:0] row;
    logic [CW-1:0] bit_cnt;
    logic          last_bit;
    logic          last_row;

    assign last_bit = (bit_cnt == LAST_BIT);
    assign last_row = (row == LAST_ROW);

    // Shifter controls stay combinational so ABORT and SERIAL_READY take
    // effect in the same cycle; LOAD and SHIFT are exclusive states, so the
    // two enables can never be high together.
    assign LOAD_EN  = (state == LOAD) & ~ABORT;
    assign SHIFT_EN = (state == SHIFT) & SERIAL_READY & ~ABORT;
    assign ROW_ADDR = row;

    // Frame FSM with row/bit counters and registered framing strobes.
    // NOTE: asynchronous reset clears every register here; state is updated
    // with non-blocking assignments so all strobes see the pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            row        <= '0;
            bit_cnt    <= '0;
            BIT_VALID  <= 1'b0;
            ROW_LAST   <= 1'b0;
            FRAME_LAST <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            // Strobes follow the shift issued this cycle, matching the edge on
            // which the shifter presents the corresponding bit.
            BIT_VALID  <= SHIFT_EN;
            ROW_LAST   <= SHIFT_EN & last_bit;
            FRAME_LAST <= SHIFT_EN & last_bit & last_row;
            DONE       <= 1'b0;

            if (ABORT && state != IDLE) begin
                state   <= IDLE;
                row     <= '0;
                bit_cnt <= '0;
                BUSY    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (START && !ABORT) begin
                            state   <= FETCH;
                            row     <= '0;
                            bit_cnt <= '0;
                            BUSY    <= 1'b1;
                        end
                    end
                    FETCH: state <= LOAD;
                    LOAD:  state <= SHIFT;
                    SHIFT: begin
                        if (SERIAL_READY) begin
                            if (last_bit) begin
                                bit_cnt <= '0;
                                if (last_row) begin
                                    state <= DRAIN;
                                    DONE  <= 1'b1;
                                end else begin
                                    row   <= row + AW'(1);
                                    state <= FETCH;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                    end
                    DRAIN: begin
                        state <= IDLE;
                        row   <= '0;
                        BUSY  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_p2s_frame_sequencer.sv
// tb_p2s_frame_sequencer
// Two sequencer instances (8-bit x 4 rows, 4-bit x 1 row) each driving a bench
// memory and shifter. A frame-position model predicts every output each cycle;
// directed scenarios add hand-computed literal expectations.
module tb_p2s_frame_sequencer;

    localparam int D0 = 8;
    localparam int N0 = 4;
    localparam int D1 = 4;
    localparam int N1 = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start, abort, ready;
    wire  [1:0] load_en, shift_en, bit_valid, row_last, frame_last, busy, done;
    wire  [1:0] ra0;
    wire  [0:0] ra1;

    always #5 clk = ~clk;

    p2s_frame_sequencer #(.DATA_SIZE(D0), .NUM_ROWS(N0)) u0 (
        .CLK(clk), .RST(rst), .START(start[0]), .ABORT(abort[0]),
        .SERIAL_READY(ready[0]), .ROW_ADDR(ra0), .LOAD_EN(load_en[0]),
        .SHIFT_EN(shift_en[0]), .BIT_VALID(bit_valid[0]), .ROW_LAST(row_last[0]),
        .FRAME_LAST(frame_last[0]), .BUSY(busy[0]), .DONE(done[0])
    );

    p2s_frame_sequencer #(.DATA_SIZE(D1), .NUM_ROWS(N1)) u1 (
        .CLK(clk), .RST(rst), .START(start[1]), .ABORT(abort[1]),
        .SERIAL_READY(ready[1]), .ROW_ADDR(ra1), .LOAD_EN(load_en[1]),
        .SHIFT_EN(shift_en[1]), .BIT_VALID(bit_valid[1]), .ROW_LAST(row_last[1]),
        .FRAME_LAST(frame_last[1]), .BUSY(busy[1]), .DONE(done[1])
    );

    // Board memory (1-cycle read latency) and parallel-to-serial shifters
    logic [7:0] mem [2][4];
    logic [7:0] mem_q [2];
    logic [7:0] sreg [2];
    logic [1:0] data;

    always @(posedge clk) begin
        mem_q[0] <= mem[0][int'(ra0)];
        mem_q[1] <= mem[1][int'(ra1)];
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg[0] <= '0;
            sreg[1] <= '0;
            data    <= '0;
        end else begin
            if (load_en[0]) sreg[0] <= mem_q[0];
            else if (shift_en[0]) begin
                data[0] <= sreg[0][0];
                sreg[0] <= sreg[0] >> 1;
            end
            if (load_en[1]) sreg[1] <= mem_q[1];
            else if (shift_en[1]) begin
                data[1] <= sreg[1][0];
                sreg[1] <= sreg[1] >> 1;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: frame position k counts non-stalled cycles since START
    bit  m_active [2];
    int  m_k      [2];
    int  m_stalls [2];
    bit  e_bv [2], e_rl [2], e_fl [2], e_bit [2];

    // Observed statistics, compared against literals by the directed tests
    int          s_bv [2], s_rl [2], s_done [2], done_cyc [2], fl_cyc [2], t0 [2];
    logic [31:0] stream [2];
    logic [7:0]  addr_seq;
    int          n_loads;

    task automatic clear_stats(input int i);
        s_bv[i] = 0; s_rl[i] = 0; s_done[i] = 0; done_cyc[i] = -1; fl_cyc[i] = -1;
        stream[i] = '0; m_stalls[i] = 0;
        if (i == 0) begin
            addr_seq = '0;
            n_loads  = 0;
        end
    endtask

    task automatic model_step(input int i);
        int d, n, len, r, off, bitn, ra;
        bit in_frame, in_drain, is_shift, el, es;
        d   = (i == 0) ? D0 : D1;
        n   = (i == 0) ? N0 : N1;
        len = n * (d + 2);
        ra  = (i == 0) ? int'(ra0) : int'(ra1);
        if (rst) begin
            check($sformatf("u%0d rst busy", i), busy[i], 0);
            check($sformatf("u%0d rst load_en", i), load_en[i], 0);
            check($sformatf("u%0d rst shift_en", i), shift_en[i], 0);
            check($sformatf("u%0d rst bit_valid", i), bit_valid[i], 0);
            check($sformatf("u%0d rst done", i), done[i], 0);
            check($sformatf("u%0d rst row_addr", i), ra, 0);
            m_active[i] = 0; m_k[i] = 0;
            e_bv[i] = 0; e_rl[i] = 0; e_fl[i] = 0;
            return;
        end
        in_frame = m_active[i] && m_k[i] <= len;
        in_drain = m_active[i] && m_k[i] == len + 1;
        r        = in_frame ? (m_k[i] - 1) / (d + 2) : (in_drain ? n - 1 : 0);
        off      = in_frame ? (m_k[i] - 1) % (d + 2) : 0;
        is_shift = in_frame && off >= 2;
        bitn     = off - 2;
        el       = in_frame && off == 1 && !abort[i];
        es       = is_shift && ready[i] && !abort[i];

        check($sformatf("u%0d row_addr", i), ra, r);
        check($sformatf("u%0d load_en", i), load_en[i], el);
        check($sformatf("u%0d shift_en", i), shift_en[i], es);
        check($sformatf("u%0d bit_valid", i), bit_valid[i], e_bv[i]);
        check($sformatf("u%0d row_last", i), row_last[i], e_rl[i]);
        check($sformatf("u%0d frame_last", i), frame_last[i], e_fl[i]);
        check($sformatf("u%0d busy", i), busy[i], m_active[i]);
        check($sformatf("u%0d done", i), done[i], in_drain);
        check($sformatf("u%0d load_and_shift", i), load_en[i] & shift_en[i], 0);
        if (e_bv[i]) check($sformatf("u%0d data", i), data[i], e_bit[i]);

        if (bit_valid[i]) begin
            if (s_bv[i] < 32) stream[i][s_bv[i]] = data[i];
            s_bv[i]++;
        end
        if (row_last[i]) s_rl[i]++;
        if (done[i]) begin
            s_done[i]++;
            done_cyc[i] = cyc - t0[i] + 1;
        end
        if (frame_last[i]) fl_cyc[i] = cyc - t0[i] + 1;
        if (i == 0 && load_en[0]) begin
            if (n_loads < 4) addr_seq[2*n_loads +: 2] = ra0;
            n_loads++;
        end

        e_bv[i] = es;
        e_rl[i] = es && bitn == d - 1;
        e_fl[i] = es && bitn == d - 1 && r == n - 1;
        if (es) e_bit[i] = mem[i][r][bitn];

        if (!m_active[i]) begin
            if (start[i] && !abort[i]) begin
                m_active[i] = 1;
                m_k[i]      = 1;
            end
        end else if (abort[i] || in_drain) begin
            m_active[i] = 0;
            m_k[i]      = 0;
        end else if (is_shift && !ready[i]) begin
            m_stalls[i]++;
        end else begin
            m_k[i]++;
        end
    endtask

    // Compare process: outputs are sampled mid-cycle, away from the active edge
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int i);
        clear_stats(i);
        start[i] = 1'b1;
        tick();
        t0[i]    = cyc;
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        int w = 0;
        while (!done[i] && w < budget) begin
            tick();
            w++;
        end
        check($sformatf("u%0d done_reached", i), done[i], 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b0;
        start = '0;
        abort = '0;
        ready = 2'b11;
        for (int r = 0; r < 4; r++) begin
            mem[0][r] = 8'hA5 ^ 8'(r);
            mem[1][r] = 8'($urandom);
        end
        #2 rst = 1'b1;
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset load_en", load_en, 0);
        check("reset shift_en", shift_en, 0);
        check("reset bit_valid", bit_valid, 0);
        check("reset row_last", row_last, 0);
        check("reset frame_last", frame_last, 0);
        check("reset row_addr", ra0, 0);
        tick(2);
        rst = 1'b0;
        tick(2);

        // Full frame, READY held high
        start_frame(0);
        wait_done(0, 100);
        tick();
        check("t1 busy_after_done", busy[0], 0);
        check("t1 done_cycle", done_cyc[0], 41);
        check("t1 frame_last_cycle", fl_cyc[0], 41);
        check("t1 bit_count", s_bv[0], 32);
        check("t1 row_last_count", s_rl[0], 4);
        check("t1 stream", stream[0], 32'hA6A7A4A5);
        check("t1 row_addr_seq", addr_seq, 8'hE4);
        check("t1 done_count", s_done[0], 1);
        tick(3);

        // READY toggling every cycle: same stream, DONE delayed by the stalls
        begin
            int w = 0;
            start_frame(0);
            while (!done[0] && w < 300) begin
                ready[0] = ~ready[0];
                tick();
                w++;
            end
            check("t2 done_reached", done[0], 1);
            ready[0] = 1'b1;
            tick();
            check("t2 stalls_seen", m_stalls[0] > 0, 1);
            check("t2 done_cycle", done_cyc[0], 41 + m_stalls[0]);
            check("t2 stream", stream[0], 32'hA6A7A4A5);
            check("t2 bit_count", s_bv[0], 32);
        end
        tick(3);

        // ABORT in row 2 after three bits, then a clean replay
        start_frame(0);
        tick(25);
        abort[0] = 1'b1;
        #1;
        check("t3 shift_en_in_abort", shift_en[0], 0);
        tick();
        abort[0] = 1'b0;
        check("t3 busy_after_abort", busy[0], 0);
        check("t3 row_addr_after_abort", ra0, 0);
        tick(5);
        check("t3 bit_count", s_bv[0], 19);
        check("t3 row_last_count", s_rl[0], 2);
        check("t3 no_done", s_done[0], 0);
        start_frame(0);
        wait_done(0, 100);
        tick();
        check("t3 replay_stream", stream[0], 32'hA6A7A4A5);
        check("t3 replay_done_cycle", done_cyc[0], 41);
        tick(3);

        // Asynchronous reset in the middle of row 1
        start_frame(0);
        tick(13);
        #2 rst = 1'b1;
        #1;
        check("t4 busy", busy[0], 0);
        check("t4 shift_en", shift_en[0], 0);
        check("t4 bit_valid", bit_valid[0], 0);
        check("t4 row_addr", ra0, 0);
        tick(2);
        rst = 1'b0;
        tick(5);
        check("t4 idle_after_release", busy[0], 0);

        // START during SHIFT is ignored; START+ABORT in IDLE stays idle
        start_frame(0);
        tick(14);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        wait_done(0, 100);
        tick();
        check("t5 done_cycle", done_cyc[0], 41);
        check("t5 bit_count", s_bv[0], 32);
        tick(2);
        start[0] = 1'b1;
        abort[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        abort[0] = 1'b0;
        check("t5 start_abort_idle", busy[0], 0);
        tick(2);

        // Single 4-bit row, START held high: back-to-back frames
        clear_stats(1);
        start[1] = 1'b1;
        tick();
        t0[1] = cyc;
        wait_done(1, 50);
        tick();
        check("t6 done_cycle", done_cyc[1], 7);
        check("t6 idle_cycle8", busy[1], 0);
        tick();
        check("t6 fetch_cycle9_busy", busy[1], 1);
        check("t6 fetch_cycle9_no_load", load_en[1], 0);
        tick();
        check("t6 load_cycle10", load_en[1], 1);
        start[1] = 1'b0;
        wait_done(1, 50);
        tick(3);

        // Randomized traffic on both instances against the model
        for (int r = 0; r < 4; r++) begin
            mem[0][r] = 8'($urandom);
            mem[1][r] = 8'($urandom);
        end
        clear_stats(0);
        clear_stats(1);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                ready[i] = ($urandom_range(0, 3) != 0);
                start[i] = ($urandom_range(0, 7) == 0);
                abort[i] = ($urandom_range(0, 63) == 0);
            end
            tick();
        end
        start = '0;
        abort = '0;
        ready = 2'b11;
        tick(60);
        check("t7 u0 frames_completed", s_done[0] > 0, 1);
        check("t7 u1 frames_completed", s_done[1] > 0, 1);
        check("t7 u0 idle_at_end", busy[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/p2s_frame_sequencer.md
# p2s_frame_sequencer

Sequences a full board frame out through one `PARALLEL_TO_SERIAL` instance. For each row it reads the row from a synchronous board memory (1-cycle read latency), pulses the shifter's load, then drives `DATA_SIZE` gated shifts. It emits framing strobes aligned to the shifter's serial `DATA` output. It sits between the generation/board memory and the serial display/link output, and shares `CLK`/`RST` with the shifter it drives.

## Interface
- `DATA_SIZE`, default 64: row width in bits; must equal the shifter's `data_size`.
- `NUM_ROWS`, default 64: rows per frame, ≥1.
- `AW`, default `max(1, $clog2(NUM_ROWS))`: row address width (derived).

- `CLK`  in  1  clock
- `RST`  in  1  reset, asynchronous, active-high
- `START`  in  1  frame request; sampled only in IDLE
- `ABORT`  in  1  synchronous frame cancel; dominant over all other inputs
- `SERIAL_READY`  in  1  downstream can accept a bit; gates shifting
- `ROW_ADDR`  out  AW  board memory read address
- `LOAD_EN`  out  1  to shifter `LOAD_EN`
- `SHIFT_EN`  out  1  to shifter `SHIFT_EN`
- `BIT_VALID`  out  1  shifter `DATA` holds a new bit this cycle
- `ROW_LAST`  out  1  with `BIT_VALID`: bit is the last of its row
- `FRAME_LAST`  out  1  with `BIT_VALID`: bit is the last of the frame
- `BUSY`  out  1  state ≠ IDLE
- `DONE`  out  1  one-cycle frame-complete pulse

## Operation
- States: IDLE, FETCH, LOAD, SHIFT, DRAIN.
- IDLE:
  - `START`=1 and `ABORT`=0 → FETCH, with row 0 and bit counter 0.
  - `START` in any other state is ignored.
- FETCH: `ROW_ADDR` = current row. → LOAD next cycle.
- LOAD: `ROW_ADDR` is held and `LOAD_EN`=1 for exactly this cycle. Memory data is valid at the shifter input this cycle. → SHIFT.
- SHIFT:
  - `SHIFT_EN` = `SERIAL_READY` & ~`ABORT` (combinational).
  - Bit counter (width `$clog2(DATA_SIZE)+1`) increments on each shift.
  - `SERIAL_READY`=0 stalls: counter and state hold, `SHIFT_EN`=0.
  - On the shift with counter = `DATA_SIZE`-1: counter clears.
    - Not the last row: row increments → FETCH.
    - Last row (`NUM_ROWS`-1): → DRAIN.
- DRAIN: one cycle, presents the final bit. `DONE`=1. → IDLE. Row resets to 0.
- Registered strobes, updated every edge:
  - `BIT_VALID` ≤ `SHIFT_EN`.
  - `ROW_LAST` ≤ `SHIFT_EN` & (counter = `DATA_SIZE`-1).
  - `FRAME_LAST` ≤ `ROW_LAST` condition & last row.
  - This aligns them with the shifter's registered `DATA`, which updates on the same edge.
- Bit order on `DATA`: row bit 0 first, bit `DATA_SIZE`-1 last. Rows go 0 → `NUM_ROWS`-1.
- `ABORT`=1 in any non-IDLE state:
  - → IDLE next edge; row and counter clear.
  - `SHIFT_EN` and `LOAD_EN` are forced 0 that cycle; no `DONE`.
  - A `BIT_VALID` already presented in the `ABORT` cycle stands. Strobes are 0 afterward.
- `ABORT` in IDLE has no effect and blocks a simultaneous `START`.
- `LOAD_EN` and `SHIFT_EN` are never both 1.

## Timing
- Reset values: state IDLE, `ROW_ADDR`=0, counter 0. `LOAD_EN`, `SHIFT_EN`, `BIT_VALID`, `ROW_LAST`, `FRAME_LAST`, `BUSY`, `DONE` are all 0.
- Reset mid-frame returns to IDLE immediately. The shifter is cleared by the same `RST`.
- Cycle numbering: `START` is accepted at edge 0.
  - Cycle 1: FETCH. Cycle 2: LOAD. Cycles 3..`DATA_SIZE`+2: SHIFT.
  - First `BIT_VALID` is in cycle 4, if `SERIAL_READY` is continuously 1.
- Row period: `DATA_SIZE`+2 cycles, with no bubbles from stalls. The last bit of row r is presented during row r+1's FETCH.
- Frame: `DONE` in cycle `NUM_ROWS`×(`DATA_SIZE`+2)+1, plus one cycle per stalled SHIFT cycle. `BUSY` is 0 the cycle after `DONE`.
- Back-to-back: `START` held high restarts in the cycle after DRAIN (IDLE lasts ≥1 cycle).
- `BIT_VALID` is high for exactly one cycle per shift. Downstream samples `DATA` when `BIT_VALID`=1.

## Test plan
- `DATA_SIZE`=8, `NUM_ROWS`=4, memory row r = 8'hA5^r, READY=1, `START` pulse:
  - Expect 32 `BIT_VALID` strobes, LSB-first per row.
  - `ROW_LAST` on bits 8/16/24/32; `FRAME_LAST` and `DONE` together at cycle 41.
  - `ROW_ADDR` sequence 0,1,2,3.
- Same setup, READY toggling 1010…:
  - `SHIFT_EN` only when READY=1; identical bit stream.
  - `DONE` delayed by the count of stalled cycles.
- `ABORT` in row 2 SHIFT after 3 bits:
  - No further `SHIFT_EN`; IDLE next edge; no `DONE`; `ROW_ADDR`=0.
  - A new `START` replays from row 0 bit 0.
- `RST` asserted mid-row 1: all outputs 0 asynchronously. After release, `BUSY`=0 until `START`.
- `START` pulsed during SHIFT: ignored, and the frame length is unchanged. `START`+`ABORT` together in IDLE: stays IDLE.
- `NUM_ROWS`=1, `DATA_SIZE`=4, `START` held high: `DONE` at cycle 7, IDLE at cycle 8, next FETCH at cycle 9. `LOAD_EN` is never coincident with `SHIFT_EN`.
